// File: rtl/score_ctrl_pkg.sv
// rtl/score_ctrl_pkg.sv - shared states, point constants and score clipping for score_ctrl
package score_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_GAP,
        S_SHOW,
        S_SCORE,
        S_DONE
    } state_t;

    localparam logic [3:0] PTS_NONE  = 4'd0;
    localparam logic [3:0] PTS_SLOW  = 4'd1;
    localparam logic [3:0] PTS_MED   = 4'd2;
    localparam logic [3:0] PTS_FAST  = 4'd3;
    localparam logic [3:0] SCORE_MAX = 4'd15;

    // Limit a round's points so the running total saturates at SCORE_MAX.
    function automatic logic [3:0] clip_pts(input logic [3:0] raw, input logic [3:0] shadow);
        logic [3:0] headroom;
        headroom = SCORE_MAX - shadow;
        return (raw < headroom) ? raw : headroom;
    endfunction

endpackage

// File: rtl/score_ctrl_timer.sv
// rtl/score_ctrl_timer.sv - clearable up-counter shared by the gap and response windows
module reaction_timer #(
    parameter int GAP_CYC  = 200,
    parameter int WIN_CYC  = 1000,
    parameter int FAST_CYC = 250,
    parameter int MED_CYC  = 500
) (
    input  logic clk,
    input  logic CLR,
    input  logic clr_i,
    output logic lt_fast_o,
    output logic lt_med_o,
    output logic expired_o,
    output logic gap_end_o
);

    localparam int MAX_CYC = (GAP_CYC > WIN_CYC) ? GAP_CYC : WIN_CYC;
    localparam int TW      = $clog2(MAX_CYC);

    localparam logic [TW-1:0] FAST_T  = TW'(FAST_CYC);
    localparam logic [TW-1:0] MED_T   = TW'(MED_CYC);
    localparam logic [TW-1:0] WIN_END = TW'(WIN_CYC - 1);
    localparam logic [TW-1:0] GAP_END = TW'(GAP_CYC - 1);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

    assign lt_fast_o = (cnt_q < FAST_T);
    assign lt_med_o  = (cnt_q < MED_T);
    assign expired_o = (cnt_q == WIN_END);
    assign gap_end_o = (cnt_q == GAP_END);

endmodule

// File: rtl/score_ctrl.sv
// rtl/score_ctrl.sv - reaction-game round sequencer driving an external score accumulator
module score_ctrl
    import score_ctrl_pkg::*;
#(
    parameter int ROUNDS   = 8,
    parameter int GAP_CYC  = 200,
    parameter int WIN_CYC  = 1000,
    parameter int FAST_CYC = 250,
    parameter int MED_CYC  = 500
) (
    input  logic       clk,
    input  logic       CLR,
    input  logic       start,
    input  logic       btn,
    output logic       led_on,
    output logic       acc_clr,
    output logic       acc_ld,
    output logic [3:0] acc_d,
    output logic [3:0] round_cnt,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] ROUNDS_C = 4'(ROUNDS);

    state_t     state_q, state_d;
    logic [3:0] round_q, shadow_q;
    logic       early_q;
    logic       led_on_q, acc_clr_q, acc_ld_q, busy_q, done_q;
    logic [3:0] acc_d_q;
    logic [3:0] raw_pts, pts_d;
    logic       timer_clr, lt_fast, lt_med, expired, gap_end;

    reaction_timer #(
        .GAP_CYC (GAP_CYC),
        .WIN_CYC (WIN_CYC),
        .FAST_CYC(FAST_CYC),
        .MED_CYC (MED_CYC)
    ) u_timer (
        .clk      (clk),
        .CLR      (CLR),
        .clr_i    (timer_clr),
        .lt_fast_o(lt_fast),
        .lt_med_o (lt_med),
        .expired_o(expired),
        .gap_end_o(gap_end)
    );

    always_comb begin
        state_d = state_q;
        raw_pts = PTS_NONE;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_INIT;
            S_INIT:         state_d = S_GAP;
            S_GAP:          if (gap_end) state_d = S_SHOW;
            S_SHOW: begin
                if (btn || expired) begin
                    state_d = S_SCORE;
                    // A press on the last window cycle still scores by its timing.
                    if (btn && !early_q) begin
                        raw_pts = lt_fast ? PTS_FAST : (lt_med ? PTS_MED : PTS_SLOW);
                    end
                end
            end
            S_SCORE:        state_d = ((round_q + 4'd1) == ROUNDS_C) ? S_DONE : S_GAP;
            default:        state_d = S_IDLE;
        endcase
        pts_d     = clip_pts(raw_pts, shadow_q);
        timer_clr = (state_d != state_q) || !((state_q == S_GAP) || (state_q == S_SHOW));
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            state_q   <= S_IDLE;
            round_q   <= 4'd0;
            shadow_q  <= 4'd0;
            early_q   <= 1'b0;
            led_on_q  <= 1'b0;
            acc_clr_q <= 1'b0;
            acc_ld_q  <= 1'b0;
            acc_d_q   <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            led_on_q  <= (state_d == S_SHOW);
            acc_clr_q <= (state_d == S_INIT);
            busy_q    <= !((state_d == S_IDLE) || (state_d == S_DONE));
            done_q    <= (state_d == S_DONE);
            acc_ld_q  <= (state_d == S_SCORE) && (pts_d != 4'd0);
            acc_d_q   <= (state_d == S_SCORE) ? pts_d : 4'd0;
            if (state_d == S_INIT) begin
                round_q  <= 4'd0;
                shadow_q <= 4'd0;
                early_q  <= 1'b0;
            end else if ((state_q == S_GAP) && btn) begin
                early_q <= 1'b1;
            end else if (state_q == S_SCORE) begin
                shadow_q <= shadow_q + acc_d_q;
                round_q  <= round_q + 4'd1;
                early_q  <= 1'b0;
            end
        end
    end

    assign led_on    = led_on_q;
    assign acc_clr   = acc_clr_q;
    assign acc_ld    = acc_ld_q;
    assign acc_d     = acc_d_q;
    assign round_cnt = round_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_score_ctrl.sv
// tb/tb_score_ctrl.sv - scoreboard bench for score_ctrl (3-round and 6-round instances)
module tb_score_ctrl;

    logic       clk = 1'b0;
    logic       CLR;
    logic       start_a, btn_a, start_b, btn_b;
    logic       a_led_on, a_acc_clr, a_acc_ld, a_busy, a_done;
    logic [3:0] a_acc_d, a_round_cnt;
    logic       b_led_on, b_acc_clr, b_acc_ld, b_busy, b_done;
    logic [3:0] b_acc_d, b_round_cnt;

    int checks = 0;
    int errors = 0;
    int exp_a[$];
    int exp_b[$];
    int acc_a = 0, acc_b = 0, ld_a = 0, ld_b = 0, clr_a = 0, clr_b = 0;

    always #5 clk = ~clk;

    score_ctrl #(.ROUNDS(3), .GAP_CYC(4), .WIN_CYC(16), .FAST_CYC(4), .MED_CYC(8)) dut_a (
        .clk(clk), .CLR(CLR), .start(start_a), .btn(btn_a),
        .led_on(a_led_on), .acc_clr(a_acc_clr), .acc_ld(a_acc_ld), .acc_d(a_acc_d),
        .round_cnt(a_round_cnt), .busy(a_busy), .done(a_done)
    );

    score_ctrl #(.ROUNDS(6), .GAP_CYC(4), .WIN_CYC(16), .FAST_CYC(4), .MED_CYC(8)) dut_b (
        .clk(clk), .CLR(CLR), .start(start_b), .btn(btn_b),
        .led_on(b_led_on), .acc_clr(b_acc_clr), .acc_ld(b_acc_ld), .acc_d(b_acc_d),
        .round_cnt(b_round_cnt), .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every load and models the downstream accumulator.
    always @(negedge clk) begin
        if (CLR) begin
            acc_a = 0;
            acc_b = 0;
        end else begin
            if (a_acc_clr) begin clr_a++; acc_a = 0; end
            if (b_acc_clr) begin clr_b++; acc_b = 0; end
            if (a_acc_ld) begin
                ld_a++;
                acc_a += int'(a_acc_d);
                if (exp_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected_ld actual acc_d=%0d required no load", a_acc_d);
                end else chk("a_acc_d", int'(a_acc_d), exp_a.pop_front());
            end
            if (b_acc_ld) begin
                ld_b++;
                acc_b += int'(b_acc_d);
                if (exp_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected_ld actual acc_d=%0d required no load", b_acc_d);
                end else chk("b_acc_d", int'(b_acc_d), exp_b.pop_front());
            end
        end
    end

    function automatic logic led(input int b);
        return (b != 0) ? b_led_on : a_led_on;
    endfunction

    function automatic logic dn(input int b);
        return (b != 0) ? b_done : a_done;
    endfunction

    task automatic set_btn(input int b, input logic v);
        if (b != 0) btn_b = v; else btn_a = v;
    endtask

    task automatic pulse_start(input int b);
        if (b != 0) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_show(input int b);
        int n = 0;
        @(negedge clk);
        while (!led(b) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!led(b)) begin
            checks++; errors++;
            $display("FAIL wait_show timeout actual led_on=0 required 1");
        end
    endtask

    task automatic press_at(input int b, input int t);
        wait_show(b);
        repeat (t) @(negedge clk);
        set_btn(b, 1'b1);
        @(negedge clk);
        set_btn(b, 1'b0);
    endtask

    task automatic timeout_round(input int b, output int len);
        wait_show(b);
        len = 0;
        while (led(b) && len < 40) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic end_game(input int b, input int rounds, input int acc);
        int n = 0;
        while (!dn(b) && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (b != 0) begin
            chk("b_done", int'(b_done), 1);
            chk("b_busy", int'(b_busy), 0);
            chk("b_round_cnt", int'(b_round_cnt), rounds);
            chk("b_accum", acc_b, acc);
            chk("b_queue_empty", exp_b.size(), 0);
        end else begin
            chk("a_done", int'(a_done), 1);
            chk("a_busy", int'(a_busy), 0);
            chk("a_round_cnt", int'(a_round_cnt), rounds);
            chk("a_accum", acc_a, acc);
            chk("a_queue_empty", exp_a.size(), 0);
        end
    endtask

    initial begin
        int len, ld0, clr0;
        CLR = 1'b1;
        start_a = 1'b0; btn_a = 1'b0; start_b = 1'b0; btn_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_led_on", int'(a_led_on), 0);
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_done", int'(a_done), 0);
        chk("rst_acc_clr", int'(a_acc_clr), 0);
        chk("rst_acc_ld", int'(a_acc_ld), 0);
        chk("rst_round_cnt", int'(a_round_cnt), 0);
        CLR = 1'b0;
        @(negedge clk);

        // Six fast presses: the sixth round saturates at 15 and loads nothing.
        pulse_start(1);
        for (int r = 0; r < 6; r++) begin
            if (r < 5) exp_b.push_back(3);
            press_at(1, 1);
        end
        end_game(1, 6, 15);
        chk("b_ld_count", ld_b, 5);

        // Fast, medium, slow presses.
        clr0 = clr_a;
        pulse_start(0);
        exp_a.push_back(3); press_at(0, 2);
        exp_a.push_back(2); press_at(0, 5);
        exp_a.push_back(1); press_at(0, 10);
        end_game(0, 3, 6);
        chk("a_ld_count_g1", ld_a, 3);
        chk("a_clr_pulses_g1", clr_a - clr0, 1);

        // No presses, started from DONE: full 16-cycle windows.
        ld0 = ld_a; clr0 = clr_a;
        pulse_start(0);
        for (int r = 0; r < 3; r++) begin
            timeout_round(0, len);
            chk("a_show_len", len, 16);
        end
        end_game(0, 3, 0);
        chk("a_ld_count_g2", ld_a - ld0, 0);
        chk("a_clr_pulses_g2", clr_a - clr0, 1);

        // Early press in GAP forfeits the round; later rounds score normally.
        pulse_start(0);
        @(negedge clk);
        set_btn(0, 1'b1);
        @(negedge clk);
        set_btn(0, 1'b0);
        press_at(0, 1);
        @(negedge clk);
        chk("a_round_after_early", int'(a_round_cnt), 1);
        exp_a.push_back(3); press_at(0, 2);
        exp_a.push_back(2); press_at(0, 6);
        end_game(0, 3, 5);

        // start during SHOW is ignored.
        clr0 = clr_a;
        pulse_start(0);
        wait_show(0);
        pulse_start(0);
        exp_a.push_back(3);
        set_btn(0, 1'b1);
        @(negedge clk);
        set_btn(0, 1'b0);
        timeout_round(0, len);
        timeout_round(0, len);
        end_game(0, 3, 3);
        chk("a_clr_pulses_g4", clr_a - clr0, 1);

        // CLR mid-SHOW, then a fresh start.
        pulse_start(0);
        wait_show(0);
        repeat (3) @(negedge clk);
        CLR = 1'b1;
        #1;
        chk("clr_led_on", int'(a_led_on), 0);
        chk("clr_busy", int'(a_busy), 0);
        @(negedge clk);
        chk("clr_round_cnt", int'(a_round_cnt), 0);
        chk("clr_acc_clr", int'(a_acc_clr), 0);
        CLR = 1'b0;
        @(negedge clk);
        clr0 = clr_a;
        pulse_start(0);
        @(negedge clk);
        chk("restart_clr_pulse", clr_a - clr0, 1);
        chk("restart_round_cnt", int'(a_round_cnt), 0);
        chk("restart_busy", int'(a_busy), 1);
        end_game(0, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
